// File: rtl/branch_target_predictor_if.sv
// branch_target_predictor_if: fetch lookup, resolved-branch update and statistics bundle
interface branch_target_predictor_if #(parameter int CNT_W = 32);
  logic [31:0]      lookup_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             upd_en;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             upd_mispred;
  logic             flush;
  logic [CNT_W-1:0] lookup_count;
  logic [CNT_W-1:0] mispred_count;
  modport master (
    output lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispred, flush,
    input  pred_hit, pred_taken, pred_target, lookup_count, mispred_count
  );
  modport slave (
    input  lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispred, flush,
    output pred_hit, pred_taken, pred_target, lookup_count, mispred_count
  );
endinterface

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with saturating direction counters
module branch_target_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 32
) (
  input logic CLK,
  input logic nRST,
  branch_target_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d [ENTRIES];
  logic [TAG_W-1:0]    tag_q [ENTRIES];
  logic [TAG_W-1:0]    tag_d [ENTRIES];
  logic [31:0]         tgt_q [ENTRIES];
  logic [31:0]         tgt_d [ENTRIES];
  logic [CNT_W-1:0]    lcnt_q, lcnt_d, mcnt_q, mcnt_d;
  logic [IDX_W-1:0]    li, ui;
  logic [TAG_W-1:0]    lt, ut;
  logic                u_hit;
  assign li = bus.lookup_pc[IDX_W+1:2];
  assign lt = bus.lookup_pc[31:IDX_W+2];
  assign ui = bus.upd_pc[IDX_W+1:2];
  assign ut = bus.upd_pc[31:IDX_W+2];
  assign u_hit = valid_q[ui] && tag_q[ui] == ut;
  assign bus.pred_hit      = valid_q[li] && tag_q[li] == lt;
  assign bus.pred_taken    = bus.pred_hit && ctr_q[li][CTR_BITS-1];
  assign bus.pred_target   = bus.pred_taken ? tgt_q[li] : bus.lookup_pc + 32'd4;
  assign bus.lookup_count  = lcnt_q;
  assign bus.mispred_count = mcnt_q;
  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    lcnt_d  = lcnt_q + CNT_W'(bus.upd_en);
    mcnt_d  = mcnt_q + CNT_W'(bus.upd_en && bus.upd_mispred);
    if (bus.upd_en && u_hit) begin
      ctr_d[ui] = bus.upd_taken ? (ctr_q[ui] == CTR_MAX ? CTR_MAX : ctr_q[ui] + 1'b1)
                                : (ctr_q[ui] == '0 ? '0 : ctr_q[ui] - 1'b1);
      tgt_d[ui] = bus.upd_taken ? bus.upd_target : tgt_q[ui];
    end else if (bus.upd_en && bus.upd_taken) begin
      valid_d[ui] = 1'b1;
      tag_d[ui]   = ut;
      tgt_d[ui]   = bus.upd_target;
      ctr_d[ui]   = CTR_WT;
    end
    // flush overrides any allocation made in the same cycle
    if (bus.flush) valid_d = '0;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      lcnt_q  <= '0;
      mcnt_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_WNT;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      lcnt_q  <= lcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end
endmodule
